// File: rtl/branch_predictor_table.sv
// Direct-mapped branch target buffer with saturating direction counters; lookup is combinational (0 cycles), an update commits on the next posedge.
// No backpressure: one lookup and one update accepted every cycle; flush wins over a same-cycle update.
// Optional BPT_BYPASS_EN forwards a same-cycle update to a lookup of the same index and tag.
module branch_predictor_table #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int PC_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [PC_W-1:0] lk_pc,
  output logic            lk_hit,
  output logic            lk_taken,
  output logic [PC_W-1:0] lk_dest,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_dest
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = PC_W - IDX - 2;

  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_ONE << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_ONE;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [ENTRIES-1:0]  valid_q;
  logic [TW-1:0]       tag_q  [ENTRIES];
  logic [PC_W-1:0]     dest_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q  [ENTRIES];

  logic [IDX-1:0] lk_idx;
  logic [IDX-1:0] upd_idx;
  logic [TW-1:0]  lk_tag;
  logic [TW-1:0]  upd_tag;

  assign lk_idx  = lk_pc[IDX+1:2];
  assign lk_tag  = lk_pc[PC_W-1:IDX+2];
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[PC_W-1:IDX+2];

  // Byte offset within the instruction word plays no part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  logic                upd_hit;
  logic                upd_wr;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_new;
  logic [PC_W-1:0]     dest_new;

  always_comb begin
    ctr_cur  = ctr_q[upd_idx];
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_wr   = 1'b0;
    ctr_new  = ctr_cur;
    dest_new = dest_q[upd_idx];
    if (upd_en && !flush) begin
      if (upd_hit) begin
        upd_wr = 1'b1;
        if (upd_taken) begin
          ctr_new  = (ctr_cur == CTR_MAX) ? CTR_MAX : ctr_cur + CTR_ONE;
          dest_new = upd_dest;
        end else begin
          ctr_new  = (ctr_cur == '0) ? '0 : ctr_cur - CTR_ONE;
        end
      end else if (upd_taken) begin
        // Taken miss allocates and evicts whatever aliased into this slot.
        upd_wr   = 1'b1;
        ctr_new  = CTR_WT;
        dest_new = upd_dest;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= '0;
        dest_q[i] <= '0;
        ctr_q[i]  <= CTR_WNT;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (upd_wr) begin
      valid_q[upd_idx] <= 1'b1;
      tag_q[upd_idx]   <= upd_tag;
      dest_q[upd_idx]  <= dest_new;
      ctr_q[upd_idx]   <= ctr_new;
    end
  end

  logic st_hit;
  assign st_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

`ifdef BPT_BYPASS_EN
  // A non-writing update leaves the entry as stored, so only real writes are forwarded.
  logic fwd;
  assign fwd = upd_wr && !rst && (lk_idx == upd_idx) && (lk_tag == upd_tag);

  always_comb begin
    if (fwd) begin
      lk_hit   = 1'b1;
      lk_taken = ctr_new[CTR_BITS-1];
      lk_dest  = dest_new;
    end else begin
      lk_hit   = st_hit;
      lk_taken = st_hit && ctr_q[lk_idx][CTR_BITS-1];
      lk_dest  = st_hit ? dest_q[lk_idx] : '0;
    end
  end
`else
  assign lk_hit   = st_hit;
  assign lk_taken = st_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign lk_dest  = st_hit ? dest_q[lk_idx] : '0;
`endif

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed and randomized bench for branch_predictor_table against a line-address reference model.
module tb_branch_predictor_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] lk_pc = '0;
  logic        lk_hit;
  logic        lk_taken;
  logic [31:0] lk_dest;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_dest = '0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  branch_predictor_table #(.ENTRIES(16), .CTR_BITS(2), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_dest(lk_dest),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_dest(upd_dest)
  );

  // Model: each slot remembers the full word address (pc>>2) it holds and a plain integer counter 0..3.
  bit          mv    [16];
  logic [29:0] mline [16];
  logic [31:0] mdest [16];
  int          mctr  [16];

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0; mline[i] = '0; mdest[i] = '0; mctr[i] = 1;
    end
  endfunction

  function automatic void model_update(input logic en, input logic fl, input logic [31:0] pc,
                                       input logic tk, input logic [31:0] dst);
    int i;
    bit hit;
    i = int'(pc[5:2]);
    if (fl) begin
      for (int k = 0; k < 16; k++) mv[k] = 0;
    end else if (en) begin
      hit = mv[i] && (mline[i] == pc[31:2]);
      if (hit && tk) begin
        mctr[i] = (mctr[i] + 1 > 3) ? 3 : mctr[i] + 1;
        mdest[i] = dst;
      end else if (hit) begin
        mctr[i] = (mctr[i] - 1 < 0) ? 0 : mctr[i] - 1;
      end else if (tk) begin
        mv[i] = 1; mline[i] = pc[31:2]; mdest[i] = dst; mctr[i] = 2;
      end
    end
  endfunction

  function automatic void exp_look(input logic [31:0] pc, output logic eh, output logic et,
                                   output logic [31:0] ed);
    int i;
    i  = int'(pc[5:2]);
    eh = mv[i] && (mline[i] == pc[31:2]);
    et = eh && (mctr[i] >= 2);
    ed = eh ? mdest[i] : 32'h0;
  endfunction

  task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tg, got, exp);
    end
  endtask

  // One cycle: drive after negedge, check lookup against the model, then commit the model at posedge.
  task automatic step(input string tg, input logic [31:0] lpc, input logic en, input logic fl,
                      input logic [31:0] upc, input logic tk, input logic [31:0] dst);
    logic eh, et;
    logic [31:0] ed;
    bit          sv [16];
    logic [29:0] sl [16];
    logic [31:0] sd [16];
    int          sc [16];
    @(negedge clk);
    lk_pc = lpc; upd_en = en; flush = fl; upd_pc = upc; upd_taken = tk; upd_dest = dst;
    #1;
    exp_look(lpc, eh, et, ed);
`ifdef BPT_BYPASS_EN
    if (en && !fl && (lpc[31:2] == upc[31:2])) begin
      sv = mv; sl = mline; sd = mdest; sc = mctr;
      model_update(en, fl, upc, tk, dst);
      exp_look(lpc, eh, et, ed);
      mv = sv; mline = sl; mdest = sd; mctr = sc;
    end
`endif
    chk({tg, ".hit"}, {31'b0, lk_hit}, {31'b0, eh});
    chk({tg, ".taken"}, {31'b0, lk_taken}, {31'b0, et});
    chk({tg, ".dest"}, lk_dest, ed);
    @(posedge clk);
    model_update(en, fl, upc, tk, dst);
  endtask

  // Idle-cycle lookup checked against fixed expectations.
  task automatic look(input string tg, input logic [31:0] lpc, input logic eh, input logic et,
                      input logic [31:0] ed);
    @(negedge clk);
    lk_pc = lpc; upd_en = 1'b0; flush = 1'b0;
    #1;
    chk({tg, ".hit"}, {31'b0, lk_hit}, {31'b0, eh});
    chk({tg, ".taken"}, {31'b0, lk_taken}, {31'b0, et});
    chk({tg, ".dest"}, lk_dest, ed);
  endtask

  initial begin
    logic [31:0] rpc, lpc;
    logic ren, rfl, rtk;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    look("reset", 32'h40, 1'b0, 1'b0, 32'h0);

    step("alloc", 32'h0, 1'b1, 1'b0, 32'h1004, 1'b1, 32'h2000);
    look("alloc_vis", 32'h1004, 1'b1, 1'b1, 32'h2000);

    for (int k = 0; k < 3; k++) step("train_t", 32'h0, 1'b1, 1'b0, 32'h1004, 1'b1, 32'h2000);
    look("sat_max", 32'h1004, 1'b1, 1'b1, 32'h2000);
    step("train_nt1", 32'h0, 1'b1, 1'b0, 32'h1004, 1'b0, 32'hdead0000);
    look("ctr2", 32'h1004, 1'b1, 1'b1, 32'h2000);
    step("train_nt2", 32'h0, 1'b1, 1'b0, 32'h1004, 1'b0, 32'hdead0000);
    look("ctr1", 32'h1004, 1'b1, 1'b0, 32'h2000);
    step("train_nt3", 32'h0, 1'b1, 1'b0, 32'h1004, 1'b0, 32'h0);
    step("train_nt4", 32'h0, 1'b1, 1'b0, 32'h1004, 1'b0, 32'h0);
    look("sat_zero", 32'h1004, 1'b1, 1'b0, 32'h2000);
    step("retrain", 32'h0, 1'b1, 1'b0, 32'h1004, 1'b1, 32'h2000);
    look("ctr_from0", 32'h1004, 1'b1, 1'b0, 32'h2000);

    step("alias_nt", 32'h0, 1'b1, 1'b0, 32'h5004, 1'b0, 32'h7777);
    look("alias_nt_keep", 32'h1004, 1'b1, 1'b0, 32'h2000);
    look("alias_nt_miss", 32'h5004, 1'b0, 1'b0, 32'h0);
    step("alias_t", 32'h0, 1'b1, 1'b0, 32'h2004, 1'b1, 32'h3000);
    look("alias_evict", 32'h1004, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h2004, 1'b1, 1'b1, 32'h3000);
    look("ignore_lsb", 32'h2007, 1'b1, 1'b1, 32'h3000);

    step("flush_upd", 32'h0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h4444);
    look("flush_108", 32'h108, 1'b0, 1'b0, 32'h0);
    look("flush_2004", 32'h2004, 1'b0, 1'b0, 32'h0);

    step("realloc", 32'h0, 1'b1, 1'b0, 32'h2004, 1'b1, 32'h3100);
    look("realloc_vis", 32'h2004, 1'b1, 1'b1, 32'h3100);
    @(negedge clk);
    lk_pc = 32'h2004; upd_en = 1'b0; flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst.hit", {31'b0, lk_hit}, 32'h0);
    chk("async_rst.taken", {31'b0, lk_taken}, 32'h0);
    chk("async_rst.dest", lk_dest, 32'h0);
    model_reset();
    #1 rst = 1'b0;

    step("same_cyc", 32'h10, 1'b1, 1'b0, 32'h10, 1'b1, 32'h400);
    look("same_cyc_next", 32'h10, 1'b1, 1'b1, 32'h400);
    step("idx_tag_mis", 32'h50, 1'b1, 1'b0, 32'h10, 1'b1, 32'h500);

    for (int n = 0; n < 3000; n++) begin
      rpc = ({$urandom_range(0, 3)} << 6) | ({$urandom_range(0, 15)} << 2) | {$urandom_range(0, 3)};
      lpc = ($urandom_range(0, 2) == 0) ? rpc
          : (({$urandom_range(0, 3)} << 6) | ({$urandom_range(0, 15)} << 2));
      ren = ($urandom_range(0, 3) != 0);
      rfl = ($urandom_range(0, 49) == 0);
      rtk = $urandom_range(0, 1) == 1;
      step("rand", lpc, ren, rfl, rpc, rtk, $urandom & 32'hffff_fffc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
